// File: rtl/reservation_station.sv
// Reservation station for ALU-class instructions: wake-up from ALU/LSB broadcasts, one dispatch per cycle.
// Optional macro RS_OLDEST_FIRST_EN switches dispatch selection from lowest-index to oldest-first.
module reservation_station #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = 3,
    parameter int ROB_W    = 4,
    parameter int OP_W     = 6,
    parameter int DATA_W   = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              issue_ready,
    input  logic              issue_rs_ready,
    input  logic [ROB_W-1:0]  issue_rob_index,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_rs1_val,
    input  logic [DATA_W-1:0] issue_rs2_val,
    input  logic [ROB_W-1:0]  issue_rs1_depend,
    input  logic [ROB_W-1:0]  issue_rs2_depend,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_PC,
    input  logic              issue_pred_br,
    input  logic              alu_ready,
    input  logic [ROB_W-1:0]  alu_rob_index,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              lsb_ready,
    input  logic [ROB_W-1:0]  lsb_rob_index,
    input  logic [DATA_W-1:0] lsb_result,
    output logic              rs_full,
    output logic              rs_to_alu_valid,
    output logic [OP_W-1:0]   rs_to_alu_op,
    output logic [DATA_W-1:0] rs_to_alu_rs1_val,
    output logic [DATA_W-1:0] rs_to_alu_rs2_val,
    output logic [DATA_W-1:0] rs_to_alu_imm,
    output logic [DATA_W-1:0] rs_to_alu_PC,
    output logic [ROB_W-1:0]  rs_to_alu_rob_index,
    output logic              rs_to_alu_pred_br
);

    localparam int CNT_W = RS_IDX_W + 1;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] pred_q, pred_d;
    logic [OP_W-1:0]    op_q      [RS_SIZE];
    logic [OP_W-1:0]    op_d      [RS_SIZE];
    logic [ROB_W-1:0]   rob_q     [RS_SIZE];
    logic [ROB_W-1:0]   rob_d     [RS_SIZE];
    logic [DATA_W-1:0]  rs1_val_q [RS_SIZE];
    logic [DATA_W-1:0]  rs1_val_d [RS_SIZE];
    logic [DATA_W-1:0]  rs2_val_q [RS_SIZE];
    logic [DATA_W-1:0]  rs2_val_d [RS_SIZE];
    logic [ROB_W-1:0]   rs1_dep_q [RS_SIZE];
    logic [ROB_W-1:0]   rs1_dep_d [RS_SIZE];
    logic [ROB_W-1:0]   rs2_dep_q [RS_SIZE];
    logic [ROB_W-1:0]   rs2_dep_d [RS_SIZE];
    logic [DATA_W-1:0]  imm_q     [RS_SIZE];
    logic [DATA_W-1:0]  imm_d     [RS_SIZE];
    logic [DATA_W-1:0]  pc_q      [RS_SIZE];
    logic [DATA_W-1:0]  pc_d      [RS_SIZE];

    // Operand values/tags as they would look after this edge's wake-up.
    logic [DATA_W-1:0]  rs1_wk_val [RS_SIZE];
    logic [DATA_W-1:0]  rs2_wk_val [RS_SIZE];
    logic [ROB_W-1:0]   rs1_wk_dep [RS_SIZE];
    logic [ROB_W-1:0]   rs2_wk_dep [RS_SIZE];
    logic [RS_SIZE-1:0] rs1_alu_hit, rs1_lsb_hit, rs2_alu_hit, rs2_lsb_hit;
    logic [RS_SIZE-1:0] ready;

    logic                ins_found, ins_en, disp_found;
    logic [RS_IDX_W-1:0] ins_idx, disp_idx;
    logic [CNT_W-1:0]    busy_cnt;

    logic                in1_alu_hit, in1_lsb_hit, in2_alu_hit, in2_lsb_hit;
    logic [DATA_W-1:0]   in1_val, in2_val;
    logic [ROB_W-1:0]    in1_dep, in2_dep;

`ifdef RS_OLDEST_FIRST_EN
    logic [CNT_W-1:0] age_q [RS_SIZE];
    logic [CNT_W-1:0] age_d [RS_SIZE];
    logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d;
`endif

    function automatic logic tag_hit(input logic vld, input logic [ROB_W-1:0] tag,
                                     input logic [ROB_W-1:0] dep);
        return vld && (dep != '0) && (tag == dep);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            assign rs1_alu_hit[gi] = tag_hit(alu_ready, alu_rob_index, rs1_dep_q[gi]);
            assign rs1_lsb_hit[gi] = tag_hit(lsb_ready, lsb_rob_index, rs1_dep_q[gi]);
            assign rs2_alu_hit[gi] = tag_hit(alu_ready, alu_rob_index, rs2_dep_q[gi]);
            assign rs2_lsb_hit[gi] = tag_hit(lsb_ready, lsb_rob_index, rs2_dep_q[gi]);
            assign rs1_wk_val[gi]  = rs1_alu_hit[gi] ? alu_result :
                                     rs1_lsb_hit[gi] ? lsb_result : rs1_val_q[gi];
            assign rs2_wk_val[gi]  = rs2_alu_hit[gi] ? alu_result :
                                     rs2_lsb_hit[gi] ? lsb_result : rs2_val_q[gi];
            assign rs1_wk_dep[gi]  = (rs1_alu_hit[gi] || rs1_lsb_hit[gi]) ? '0 : rs1_dep_q[gi];
            assign rs2_wk_dep[gi]  = (rs2_alu_hit[gi] || rs2_lsb_hit[gi]) ? '0 : rs2_dep_q[gi];
            assign ready[gi] = busy_q[gi] && (rs1_dep_q[gi] == '0) && (rs2_dep_q[gi] == '0);
        end
    endgenerate

    // Incoming operands may be satisfied by a broadcast in the same cycle.
    assign in1_alu_hit = tag_hit(alu_ready, alu_rob_index, issue_rs1_depend);
    assign in1_lsb_hit = tag_hit(lsb_ready, lsb_rob_index, issue_rs1_depend);
    assign in2_alu_hit = tag_hit(alu_ready, alu_rob_index, issue_rs2_depend);
    assign in2_lsb_hit = tag_hit(lsb_ready, lsb_rob_index, issue_rs2_depend);
    assign in1_val = in1_alu_hit ? alu_result : in1_lsb_hit ? lsb_result : issue_rs1_val;
    assign in2_val = in2_alu_hit ? alu_result : in2_lsb_hit ? lsb_result : issue_rs2_val;
    assign in1_dep = (in1_alu_hit || in1_lsb_hit) ? '0 : issue_rs1_depend;
    assign in2_dep = (in2_alu_hit || in2_lsb_hit) ? '0 : issue_rs2_depend;

    always_comb begin
        ins_found = 1'b0;
        ins_idx   = '0;
        busy_cnt  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                ins_found = 1'b1;
                ins_idx   = RS_IDX_W'(i);
            end
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
        end
    end

    assign ins_en  = issue_ready && issue_rs_ready && ins_found;
    assign rs_full = (busy_cnt >= CNT_W'(RS_SIZE - 1));

`ifdef RS_OLDEST_FIRST_EN
    // Age is the wrapped distance from the stamp to the insert counter; larger is older.
    logic [CNT_W-1:0] best_dist;
    logic [CNT_W-1:0] cur_dist;
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        best_dist  = '0;
        cur_dist   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cur_dist = ins_cnt_q - age_q[i];
            if (ready[i] && (!disp_found || (cur_dist > best_dist))) begin
                disp_found = 1'b1;
                disp_idx   = RS_IDX_W'(i);
                best_dist  = cur_dist;
            end
        end
    end
`else
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                disp_found = 1'b1;
                disp_idx   = RS_IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        busy_d = busy_q;
        pred_d = pred_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            op_d[i]      = op_q[i];
            rob_d[i]     = rob_q[i];
            rs1_val_d[i] = rs1_val_q[i];
            rs2_val_d[i] = rs2_val_q[i];
            rs1_dep_d[i] = rs1_dep_q[i];
            rs2_dep_d[i] = rs2_dep_q[i];
            imm_d[i]     = imm_q[i];
            pc_d[i]      = pc_q[i];
`ifdef RS_OLDEST_FIRST_EN
            age_d[i]     = age_q[i];
`endif
        end
`ifdef RS_OLDEST_FIRST_EN
        ins_cnt_d = ins_cnt_q;
`endif
        if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    rs1_val_d[i] = rs1_wk_val[i];
                    rs2_val_d[i] = rs2_wk_val[i];
                    rs1_dep_d[i] = rs1_wk_dep[i];
                    rs2_dep_d[i] = rs2_wk_dep[i];
                end
            end
            if (disp_found) begin
                busy_d[disp_idx] = 1'b0;
            end
            // The insert slot is chosen among non-busy entries, so it never collides with dispatch.
            if (ins_en) begin
                busy_d[ins_idx]    = 1'b1;
                pred_d[ins_idx]    = issue_pred_br;
                op_d[ins_idx]      = issue_op;
                rob_d[ins_idx]     = issue_rob_index;
                rs1_val_d[ins_idx] = in1_val;
                rs2_val_d[ins_idx] = in2_val;
                rs1_dep_d[ins_idx] = in1_dep;
                rs2_dep_d[ins_idx] = in2_dep;
                imm_d[ins_idx]     = issue_imm;
                pc_d[ins_idx]      = issue_PC;
`ifdef RS_OLDEST_FIRST_EN
                age_d[ins_idx]     = ins_cnt_q;
                ins_cnt_d          = ins_cnt_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            busy_q              <= '0;
            rs_to_alu_valid     <= 1'b0;
            rs_to_alu_op        <= '0;
            rs_to_alu_rs1_val   <= '0;
            rs_to_alu_rs2_val   <= '0;
            rs_to_alu_imm       <= '0;
            rs_to_alu_PC        <= '0;
            rs_to_alu_rob_index <= '0;
            rs_to_alu_pred_br   <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
            ins_cnt_q           <= '0;
`endif
        end else begin
            busy_q <= busy_d;
            pred_q <= pred_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]      <= op_d[i];
                rob_q[i]     <= rob_d[i];
                rs1_val_q[i] <= rs1_val_d[i];
                rs2_val_q[i] <= rs2_val_d[i];
                rs1_dep_q[i] <= rs1_dep_d[i];
                rs2_dep_q[i] <= rs2_dep_d[i];
                imm_q[i]     <= imm_d[i];
                pc_q[i]      <= pc_d[i];
`ifdef RS_OLDEST_FIRST_EN
                age_q[i]     <= age_d[i];
`endif
            end
`ifdef RS_OLDEST_FIRST_EN
            ins_cnt_q <= ins_cnt_d;
`endif
            if (!rdy_in) begin
                rs_to_alu_valid <= 1'b0;
            end else begin
                rs_to_alu_valid <= disp_found;
                if (disp_found) begin
                    rs_to_alu_op        <= op_q[disp_idx];
                    rs_to_alu_rs1_val   <= rs1_val_q[disp_idx];
                    rs_to_alu_rs2_val   <= rs2_val_q[disp_idx];
                    rs_to_alu_imm       <= imm_q[disp_idx];
                    rs_to_alu_PC        <= pc_q[disp_idx];
                    rs_to_alu_rob_index <= rob_q[disp_idx];
                    rs_to_alu_pred_br   <= pred_q[disp_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed issues push expected dispatches,
// a negedge monitor pops and compares every rs_to_alu_valid pulse including its edge number.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        issue_ready, issue_rs_ready, issue_pred_br;
    logic [3:0]  issue_rob_index, issue_rs1_depend, issue_rs2_depend;
    logic [5:0]  issue_op;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_PC;
    logic        alu_ready, lsb_ready;
    logic [3:0]  alu_rob_index, lsb_rob_index;
    logic [31:0] alu_result, lsb_result;
    logic        rs_full, rs_to_alu_valid, rs_to_alu_pred_br;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1_val, rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC;
    logic [3:0]  rs_to_alu_rob_index;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_ready(issue_ready), .issue_rs_ready(issue_rs_ready),
        .issue_rob_index(issue_rob_index), .issue_op(issue_op),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_rs1_depend(issue_rs1_depend), .issue_rs2_depend(issue_rs2_depend),
        .issue_imm(issue_imm), .issue_PC(issue_PC), .issue_pred_br(issue_pred_br),
        .alu_ready(alu_ready), .lsb_ready(lsb_ready),
        .alu_rob_index(alu_rob_index), .lsb_rob_index(lsb_rob_index),
        .alu_result(alu_result), .lsb_result(lsb_result),
        .rs_full(rs_full), .rs_to_alu_valid(rs_to_alu_valid), .rs_to_alu_op(rs_to_alu_op),
        .rs_to_alu_rs1_val(rs_to_alu_rs1_val), .rs_to_alu_rs2_val(rs_to_alu_rs2_val),
        .rs_to_alu_imm(rs_to_alu_imm), .rs_to_alu_PC(rs_to_alu_PC),
        .rs_to_alu_rob_index(rs_to_alu_rob_index), .rs_to_alu_pred_br(rs_to_alu_pred_br)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc = cyc + 1;

    typedef struct {
        logic [3:0]  rob;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic        pred;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push_exp(input logic [3:0] rob, input logic [5:0] op, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] imm, input logic [31:0] pc,
                            input logic pred, input int at);
        exp_t e;
        e.rob = rob; e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc;
        e.pred = pred; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
            $display("check %s ok (0x%0h)", nm, act);
        end else begin
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every dispatch pulse must match the head of the scoreboard, including its edge.
    always @(negedge clk_in) begin
        if (rs_to_alu_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_dispatch cyc=%0d rob=%0d rs1=0x%0h (none expected)",
                         cyc, rs_to_alu_rob_index, rs_to_alu_rs1_val);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rs_to_alu_rob_index === e.rob && rs_to_alu_op === e.op &&
                    rs_to_alu_rs1_val === e.v1 && rs_to_alu_rs2_val === e.v2 &&
                    rs_to_alu_imm === e.imm && rs_to_alu_PC === e.pc &&
                    rs_to_alu_pred_br === e.pred && cyc == e.cyc) begin
                    n_pass++;
                    $display("dispatch ok cyc=%0d rob=%0d op=%0d rs1=0x%0h rs2=0x%0h imm=0x%0h pc=0x%0h pred=%0d",
                             cyc, e.rob, e.op, e.v1, e.v2, e.imm, e.pc, e.pred);
                end else begin
                    $display("FAIL dispatch actual cyc=%0d rob=%0d op=%0d rs1=%h rs2=%h imm=%h pc=%h pred=%0d required cyc=%0d rob=%0d op=%0d rs1=%h rs2=%h imm=%h pc=%h pred=%0d",
                             cyc, rs_to_alu_rob_index, rs_to_alu_op, rs_to_alu_rs1_val,
                             rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_pred_br,
                             e.cyc, e.rob, e.op, e.v1, e.v2, e.imm, e.pc, e.pred);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] rob, input logic [5:0] op, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic pred);
        issue_ready = 1'b1; issue_rs_ready = 1'b1;
        issue_rob_index = rob; issue_op = op; issue_rs1_val = v1; issue_rs2_val = v2;
        issue_rs1_depend = d1; issue_rs2_depend = d2; issue_imm = imm; issue_PC = pc;
        issue_pred_br = pred;
        idle(1);
        issue_ready = 1'b0; issue_rs_ready = 1'b0;
    endtask

    task automatic bcast_alu(input logic [3:0] tag, input logic [31:0] val);
        alu_ready = 1'b1; alu_rob_index = tag; alu_result = val;
        idle(1);
        alu_ready = 1'b0;
    endtask

    task automatic bcast_lsb(input logic [3:0] tag, input logic [31:0] val);
        lsb_ready = 1'b1; lsb_rob_index = tag; lsb_result = val;
        idle(1);
        lsb_ready = 1'b0;
    endtask

    initial begin
        int c;
        int waited;
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
        issue_ready = 1'b0; issue_rs_ready = 1'b0; issue_pred_br = 1'b0;
        issue_rob_index = '0; issue_op = '0; issue_rs1_val = '0; issue_rs2_val = '0;
        issue_rs1_depend = '0; issue_rs2_depend = '0; issue_imm = '0; issue_PC = '0;
        alu_ready = 1'b0; lsb_ready = 1'b0; alu_rob_index = '0; lsb_rob_index = '0;
        alu_result = '0; lsb_result = '0;

        idle(3);
        rst_in = 1'b0;
        check_eq("reset_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        check_eq("reset_rob", {28'd0, rs_to_alu_rob_index}, 32'd0);
        check_eq("reset_rs1", rs_to_alu_rs1_val, 32'd0);
        check_eq("reset_full", {31'd0, rs_full}, 32'd0);

        // ADDI with no dependencies: dispatched one edge after insertion.
        c = cyc;
        push_exp(4'd3, 6'd5, 32'd5, 32'd0, 32'd1, 32'h1000, 1'b0, c + 2);
        issue(4'd3, 6'd5, 32'd5, 32'd0, 4'd0, 4'd0, 32'd1, 32'h1000, 1'b0);
        idle(2);
        check_eq("valid_one_pulse", {31'd0, rs_to_alu_valid}, 32'd0);

        // ADD waiting on tag 2, woken by the ALU three cycles later.
        issue(4'd4, 6'd1, 32'hDEAD, 32'h20, 4'd2, 4'd0, 32'd0, 32'h1004, 1'b0);
        idle(2);
        c = cyc;
        push_exp(4'd4, 6'd1, 32'h10, 32'h20, 32'd0, 32'h1004, 1'b0, c + 2);
        bcast_alu(4'd2, 32'h10);
        idle(3);

        // rs2 tag satisfied by an LSB broadcast in the issue cycle.
        lsb_ready = 1'b1; lsb_rob_index = 4'd6; lsb_result = 32'hABCD;
        c = cyc;
        push_exp(4'd5, 6'd2, 32'h7, 32'hABCD, 32'h3, 32'h1008, 1'b1, c + 2);
        issue(4'd5, 6'd2, 32'h7, 32'hBEEF, 4'd0, 4'd6, 32'h3, 32'h1008, 1'b1);
        lsb_ready = 1'b0;
        idle(3);

        // A ready entry held one extra edge by rdy_in low.
        c = cyc;
        push_exp(4'd6, 6'd3, 32'h11, 32'h22, 32'h4, 32'h100C, 1'b1, c + 3);
        issue(4'd6, 6'd3, 32'h11, 32'h22, 4'd0, 4'd0, 32'h4, 32'h100C, 1'b1);
        rdy_in = 1'b0;
        idle(1);
        check_eq("paused_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        rdy_in = 1'b1;
        idle(3);

        // Fill: 7 blocked entries raise rs_full, 8th accepted, 9th dropped.
        for (int k = 0; k < 7; k++) begin
            issue(4'(k + 1), 6'd4, 32'd0, 32'(k), 4'd9, 4'd0, 32'(k), 32'h2000 + 32'(4 * k), k[0]);
            if (k == 5) check_eq("full_at_6", {31'd0, rs_full}, 32'd0);
            if (k == 6) check_eq("full_at_7", {31'd0, rs_full}, 32'd1);
        end
        issue(4'd8, 6'd4, 32'd0, 32'd7, 4'd9, 4'd0, 32'd7, 32'h201C, 1'b1);
        issue(4'd15, 6'd9, 32'd0, 32'hFF, 4'd9, 4'd0, 32'hFF, 32'h3000, 1'b0);
        check_eq("full_after_9th", {31'd0, rs_full}, 32'd1);
        c = cyc;
        for (int k = 0; k < 8; k++)
            push_exp(4'(k + 1), 6'd4, 32'h99, 32'(k), 32'(k), 32'h2000 + 32'(4 * k), k[0], c + 2 + k);
        bcast_alu(4'd9, 32'h99);
        idle(12);
        check_eq("empty_after_drain", {31'd0, rs_full}, 32'd0);

        // Flush with pending and ready entries plus a same-cycle broadcast.
        issue(4'd10, 6'd7, 32'd0, 32'd1, 4'd11, 4'd0, 32'd0, 32'h4000, 1'b0);
        issue(4'd11, 6'd7, 32'd2, 32'd0, 4'd0, 4'd11, 32'd0, 32'h4004, 1'b0);
        issue(4'd12, 6'd7, 32'd3, 32'd4, 4'd0, 4'd0, 32'd0, 32'h4008, 1'b0);
        clr_in = 1'b1; alu_ready = 1'b1; alu_rob_index = 4'd11; alu_result = 32'h55;
        idle(1);
        clr_in = 1'b0; alu_ready = 1'b0;
        check_eq("flush_valid", {31'd0, rs_to_alu_valid}, 32'd0);
        check_eq("flush_rob", {28'd0, rs_to_alu_rob_index}, 32'd0);
        check_eq("flush_pc", rs_to_alu_PC, 32'd0);
        bcast_alu(4'd11, 32'h66);
        idle(5);

        // Age test: A dispatches, C lands in slot 0, then B and C wake together.
        issue(4'd1, 6'd8, 32'd0, 32'hB0, 4'd12, 4'd0, 32'h1, 32'h5000, 1'b0);
        issue(4'd2, 6'd8, 32'hB1, 32'd0, 4'd0, 4'd13, 32'h2, 32'h5004, 1'b0);
        c = cyc;
        push_exp(4'd1, 6'd8, 32'hA, 32'hB0, 32'h1, 32'h5000, 1'b0, c + 2);
        bcast_alu(4'd12, 32'hA);
        idle(1);
        issue(4'd3, 6'd8, 32'd0, 32'hC0, 4'd13, 4'd0, 32'h3, 32'h5008, 1'b1);
        c = cyc;
`ifdef RS_OLDEST_FIRST_EN
        push_exp(4'd2, 6'd8, 32'hB1, 32'hB, 32'h2, 32'h5004, 1'b0, c + 2);
        push_exp(4'd3, 6'd8, 32'hB, 32'hC0, 32'h3, 32'h5008, 1'b1, c + 3);
`else
        push_exp(4'd3, 6'd8, 32'hB, 32'hC0, 32'h3, 32'h5008, 1'b1, c + 2);
        push_exp(4'd2, 6'd8, 32'hB1, 32'hB, 32'h2, 32'h5004, 1'b0, c + 3);
`endif
        bcast_lsb(4'd13, 32'hB);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(3);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
